iso16_seal_scheduler: RTL and testbench
=======================================

ISO16_SEAL_SCHEDULER -- requirements
Module: iso16_seal_scheduler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NREQ  4  number of requesting True Delivery Loop instances sharing one seal engine, 2..8
  TIMEOUT  1024  max cycles waited for seal_ready_i, 2..65535
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  input  1  single clock; all logic on rising edge
  rst  input  1  reset, synchronous, active-high
  req_i  input  NREQ  per-requester seal request, level
  grant_o  output  NREQ  one-hot: requester currently owning the seal engine
  seal_start_o  output  1  one-cycle start pulse to shared seal engine
  seal_ready_i  input  1  seal engine completion, sampled only in WAIT
  seal_out_i  input  256  seal engine result, valid with seal_ready_i
  result_valid_o  output  1  result available to granted requester
  result_id_o  output  3  index of requester owning result
  result_o  output  256  captured seal value
  result_err_o  output  1  result produced by timeout, not by engine
  result_ack_i  input  1  requester consumes result
  timeout_o  output  1  one-cycle pulse on timeout
  busy_o  output  1  high in any state except IDLE
  state_o  output  2  FSM state for waveform logger tap

Function
REQ-003 FSM states SHALL be encoded IDLE=0, START=1, WAIT=2, DELIVER=3.
REQ-004 IDLE: when req_i != 0, the block SHALL select one requester round-robin, searching from (last+1) mod NREQ upward, latch its index, assert its grant_o bit, and go to START next cycle.
REQ-005 `last` SHALL reset to NREQ-1 so that requester 0 wins the first arbitration after reset.
REQ-006 START: seal_start_o SHALL be 1 for exactly this one cycle; timeout counter cleared; next state WAIT unconditionally.
REQ-007 seal_ready_i asserted in IDLE, START or DELIVER SHALL be ignored.
REQ-008 WAIT: on seal_ready_i=1 the block SHALL capture seal_out_i into result_o, clear result_err_o, and go to DELIVER.
REQ-009 WAIT: when seal_ready_i=0, the counter SHALL increment; when the counter equals TIMEOUT-1 without ready, the block SHALL pulse timeout_o, set result_o=0 and result_err_o=1, and go to DELIVER.
REQ-010 If seal_ready_i=1 in the cycle the timeout would fire, ready SHALL win and no timeout SHALL occur.
REQ-011 DELIVER: result_valid_o=1 with result_id_o = granted index, held stable until result_ack_i=1; on ack the block SHALL clear result_valid_o and grant_o, set last = granted index, and return to IDLE.
REQ-012 result_ack_i outside DELIVER SHALL be ignored.
REQ-013 Deassertion of the granted req_i bit after grant SHALL NOT abort the transaction; it completes through DELIVER.
REQ-014 grant_o SHALL be one-hot in START/WAIT/DELIVER and zero in IDLE; busy_o = (state != IDLE).
REQ-015 Minimum turnaround from req to result_valid_o SHALL be 3 cycles (IDLE->START->WAIT with ready->DELIVER); back-to-back grants SHALL have one IDLE cycle between them.
REQ-016 result_o and result_err_o SHALL hold their last value outside DELIVER; result_id_o SHALL track the latched index.

Reset
REQ-017 With rst=1 at a clock edge, the block SHALL enter IDLE and drive grant_o=0, seal_start_o=0, result_valid_o=0, result_id_o=0, result_o=0, result_err_o=0, timeout_o=0, busy_o=0, state_o=0, counter=0, last=NREQ-1, regardless of current state.
REQ-018 Reset asserted mid-transaction SHALL discard the in-flight seal; a later seal_ready_i SHALL be ignored.

Verification
REQ-019 Single request: req_i=4'b0100, engine ready 5 cycles after start with seal_out_i=0xA5..A5 -> grant_o=4'b0100, one seal_start_o pulse, result_valid_o with result_id_o=2, result_o=0xA5..A5, result_err_o=0.
REQ-020 Fairness: req_i=4'b1111 held, ready 1 cycle after each start, ack immediately -> grant order 0,1,2,3,0.
REQ-021 Timeout: TIMEOUT=16, no ready -> timeout_o pulses exactly once, 16 cycles after the START cycle, result_err_o=1, result_o=0, result_valid_o held until ack.
REQ-022 Ready/timeout coincidence: ready asserted on the final count cycle -> no timeout_o, result_err_o=0, result_o=seal_out_i.
REQ-023 Reset in WAIT: rst for 1 cycle, then ready pulse -> all outputs at reset values, no result_valid_o, next grant goes to requester 0.
REQ-024 Spurious inputs: seal_ready_i and result_ack_i pulsed in IDLE, and req withdrawn in WAIT -> no state change from IDLE; withdrawn transaction still delivers.

Source files
------------

// File: rtl/iso16_seal_scheduler.sv
// Round-robin arbiter that lends one shared seal engine to NREQ requesters,
// starts it, waits for completion or timeout, then holds the result until acked.
module iso16_seal_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o,
    output logic            seal_start_o,
    input  logic            seal_ready_i,
    input  logic [255:0]    seal_out_i,
    output logic            result_valid_o,
    output logic [2:0]      result_id_o,
    output logic [255:0]    result_o,
    output logic            result_err_o,
    input  logic            result_ack_i,
    output logic            timeout_o,
    output logic            busy_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [2:0]   last_q, last_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [255:0] result_q, result_d;
    logic         err_q, err_d;

    logic [2:0]   pick;
    logic         pick_vld;
    int           j;

    // First requester at or after last+1, wrapping modulo NREQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        j        = 0;
        for (int i = 1; i <= NREQ; i++) begin
            j = int'(last_q) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!pick_vld && req_i[j]) begin
                pick_vld = 1'b1;
                pick     = 3'(j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        err_d     = err_q;
        timeout_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    idx_d   = pick;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Ready takes priority over a timeout firing in the same cycle.
                if (seal_ready_i) begin
                    result_d = seal_out_i;
                    err_d    = 1'b0;
                    state_d  = DELIVER;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    timeout_o = 1'b1;
                    result_d  = '0;
                    err_d     = 1'b1;
                    state_d   = DELIVER;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DELIVER: begin
                if (result_ack_i) begin
                    last_d  = idx_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            last_q   <= 3'(NREQ - 1);
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign grant_o        = (state_q != IDLE) ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_q) : '0;
    assign seal_start_o   = (state_q == START);
    assign result_valid_o = (state_q == DELIVER);
    assign result_id_o    = idx_q;
    assign result_o       = result_q;
    assign result_err_o   = err_q;
    assign busy_o         = (state_q != IDLE);
    assign state_o        = state_q;

endmodule

// File: tb/tb_iso16_seal_scheduler.sv
// Directed bench for iso16_seal_scheduler: one task per scenario, inline checks.
module tb_iso16_seal_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_i;
    logic [3:0]   grant_o;
    logic         seal_start_o;
    logic         seal_ready_i;
    logic [255:0] seal_out_i;
    logic         result_valid_o;
    logic [2:0]   result_id_o;
    logic [255:0] result_o;
    logic         result_err_o;
    logic         result_ack_i;
    logic         timeout_o;
    logic         busy_o;
    logic [1:0]   state_o;

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int touts  = 0;

    iso16_seal_scheduler #(.NREQ(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .grant_o(grant_o),
        .seal_start_o(seal_start_o), .seal_ready_i(seal_ready_i),
        .seal_out_i(seal_out_i), .result_valid_o(result_valid_o),
        .result_id_o(result_id_o), .result_o(result_o),
        .result_err_o(result_err_o), .result_ack_i(result_ack_i),
        .timeout_o(timeout_o), .busy_o(busy_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (seal_start_o === 1'b1) starts++;
        if (timeout_o === 1'b1) touts++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_i = '0; seal_ready_i = 1'b0; seal_out_i = '0; result_ack_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        total++; if (grant_o !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant_o); end
        total++; if ({busy_o, seal_start_o, result_valid_o, result_err_o, timeout_o} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {busy_o, seal_start_o, result_valid_o, result_err_o, timeout_o}); end
        total++; if (result_o !== 256'h0 || result_id_o !== 3'd0) begin
            bad++; $display("FAIL reset_result got=%h id=%0d exp=0 id=0", result_o, result_id_o); end
    endtask

    task automatic test_single();
        int s0;
        s0 = starts;
        req_i = 4'b0100;
        tick();                                   // START
        total++; if (grant_o !== 4'b0100 || seal_start_o !== 1'b1) begin
            bad++; $display("FAIL single_start got grant=%b start=%b exp=0100 1", grant_o, seal_start_o); end
        req_i = 4'b0000;
        for (int k = 1; k <= 4; k++) tick();      // WAIT, cycles start+1..start+4
        total++; if (state_o !== 2'd2 || grant_o !== 4'b0100) begin
            bad++; $display("FAIL single_wait got state=%0d grant=%b exp=2 0100", state_o, grant_o); end
        tick();                                   // start+5
        seal_ready_i = 1'b1; seal_out_i = {32{8'hA5}};
        tick();                                   // DELIVER
        seal_ready_i = 1'b0; seal_out_i = '0;
        total++; if (result_valid_o !== 1'b1 || result_id_o !== 3'd2 || result_err_o !== 1'b0) begin
            bad++; $display("FAIL single_deliver got v=%b id=%0d err=%b exp=1 2 0", result_valid_o, result_id_o, result_err_o); end
        total++; if (result_o !== {32{8'hA5}}) begin bad++; $display("FAIL single_data got=%h exp=a5..a5", result_o); end
        tick();
        total++; if (result_valid_o !== 1'b1) begin bad++; $display("FAIL single_hold got=%b exp=1", result_valid_o); end
        result_ack_i = 1'b1;
        tick();
        result_ack_i = 1'b0;
        total++; if (state_o !== 2'd0 || grant_o !== 4'b0 || result_valid_o !== 1'b0) begin
            bad++; $display("FAIL single_ack got state=%0d grant=%b v=%b exp=0 0000 0", state_o, grant_o, result_valid_o); end
        total++; if (result_o !== {32{8'hA5}}) begin bad++; $display("FAIL single_keep got=%h exp=a5..a5", result_o); end
        total++; if (starts - s0 !== 1) begin bad++; $display("FAIL single_pulses got=%0d exp=1", starts - s0); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        rst = 1'b1; tick(); rst = 1'b0;
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            tick();                               // START
            total++; if (grant_o !== exp_g || seal_start_o !== 1'b1) begin
                bad++; $display("FAIL fair_grant%0d got=%b exp=%b", k, grant_o, exp_g); end
            tick();                               // WAIT
            seal_ready_i = 1'b1; seal_out_i = {8{32'h1000_0000 + k}};
            tick();                               // DELIVER
            seal_ready_i = 1'b0;
            total++; if (result_id_o !== 3'(k % 4) || result_o !== {8{32'h1000_0000 + k}}) begin
                bad++; $display("FAIL fair_result%0d got id=%0d data=%h exp id=%0d", k, result_id_o, result_o, k % 4); end
            result_ack_i = 1'b1;
            tick();                               // IDLE gap
            result_ack_i = 1'b0;
            total++; if (state_o !== 2'd0 || grant_o !== 4'b0) begin
                bad++; $display("FAIL fair_gap%0d got state=%0d grant=%b exp=0 0000", k, state_o, grant_o); end
        end
        req_i = 4'b0;
        seal_out_i = '0;
        tick();
    endtask

    task automatic test_timeout();
        int t0;
        t0 = touts;
        req_i = 4'b0010;
        tick();                                   // START
        req_i = 4'b0;
        seal_out_i = {32{8'h3C}};
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16) begin
                total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL tmo_early%0d got=1 exp=0", k); end
            end else begin
                total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL tmo_fire got=%b exp=1", timeout_o); end
            end
        end
        tick();                                   // DELIVER
        total++; if (result_err_o !== 1'b1 || result_o !== 256'h0 || result_valid_o !== 1'b1 || result_id_o !== 3'd1) begin
            bad++; $display("FAIL tmo_result got err=%b data=%h v=%b id=%0d exp=1 0 1 1", result_err_o, result_o, result_valid_o, result_id_o); end
        tick(); tick(); tick();
        total++; if (result_valid_o !== 1'b1 || timeout_o !== 1'b0) begin
            bad++; $display("FAIL tmo_hold got v=%b tmo=%b exp=1 0", result_valid_o, timeout_o); end
        result_ack_i = 1'b1;
        tick();
        result_ack_i = 1'b0;
        seal_out_i = '0;
        total++; if (touts - t0 !== 1) begin bad++; $display("FAIL tmo_count got=%0d exp=1", touts - t0); end
        total++; if (state_o !== 2'd0 || result_err_o !== 1'b1) begin
            bad++; $display("FAIL tmo_after got state=%0d err=%b exp=0 1", state_o, result_err_o); end
    endtask

    task automatic test_coincide();
        int t0;
        t0 = touts;
        req_i = 4'b0100;
        tick();                                   // START
        req_i = 4'b0;
        for (int k = 1; k <= 16; k++) tick();     // final count cycle
        seal_ready_i = 1'b1; seal_out_i = {32{8'h5A}};
        #1;
        total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL coin_tmo got=%b exp=0", timeout_o); end
        tick();
        seal_ready_i = 1'b0;
        total++; if (state_o !== 2'd3 || result_err_o !== 1'b0 || result_o !== {32{8'h5A}} || result_id_o !== 3'd2) begin
            bad++; $display("FAIL coin_result got state=%0d err=%b data=%h id=%0d exp=3 0 5a..5a 2", state_o, result_err_o, result_o, result_id_o); end
        total++; if (touts !== t0) begin bad++; $display("FAIL coin_count got=%0d exp=0", touts - t0); end
        result_ack_i = 1'b1;
        tick();
        result_ack_i = 1'b0;
        seal_out_i = '0;
    endtask

    task automatic test_reset_wait();
        req_i = 4'b1000;
        tick();                                   // START
        total++; if (grant_o !== 4'b1000) begin bad++; $display("FAIL rstw_grant got=%b exp=1000", grant_o); end
        tick(); tick();                           // WAIT
        rst = 1'b1;
        tick();
        rst = 1'b0; req_i = 4'b0;
        seal_ready_i = 1'b1; seal_out_i = {32{8'hEE}};
        #1;
        total++; if (state_o !== 2'd0 || grant_o !== 4'b0 || busy_o !== 1'b0 || result_o !== 256'h0 || result_id_o !== 3'd0) begin
            bad++; $display("FAIL rstw_values got state=%0d grant=%b busy=%b id=%0d exp=0 0000 0 0", state_o, grant_o, busy_o, result_id_o); end
        tick();
        seal_ready_i = 1'b0; seal_out_i = '0;
        total++; if (state_o !== 2'd0 || result_valid_o !== 1'b0 || result_o !== 256'h0) begin
            bad++; $display("FAIL rstw_ready got state=%0d v=%b exp=0 0", state_o, result_valid_o); end
        req_i = 4'b1001;
        tick();                                   // START
        req_i = 4'b0;
        total++; if (grant_o !== 4'b0001) begin bad++; $display("FAIL rstw_next got=%b exp=0001", grant_o); end
        tick();
        seal_ready_i = 1'b1;
        tick();
        seal_ready_i = 1'b0;
        result_ack_i = 1'b1;
        tick();
        result_ack_i = 1'b0;
    endtask

    task automatic test_spurious();
        int s0;
        s0 = starts;
        req_i = 4'b0; seal_ready_i = 1'b1; result_ack_i = 1'b1; seal_out_i = {32{8'h77}};
        tick(); tick();
        seal_ready_i = 1'b0; result_ack_i = 1'b0;
        total++; if (state_o !== 2'd0 || busy_o !== 1'b0 || result_valid_o !== 1'b0 || starts !== s0) begin
            bad++; $display("FAIL spur_idle got state=%0d busy=%b v=%b exp=0 0 0", state_o, busy_o, result_valid_o); end
        req_i = 4'b0010;
        tick();                                   // START
        tick();                                   // WAIT
        req_i = 4'b0;
        tick(); tick();
        total++; if (state_o !== 2'd2 || grant_o !== 4'b0010 || busy_o !== 1'b1) begin
            bad++; $display("FAIL spur_withdraw got state=%0d grant=%b busy=%b exp=2 0010 1", state_o, grant_o, busy_o); end
        seal_ready_i = 1'b1; seal_out_i = {32{8'h3D}};
        tick();
        seal_ready_i = 1'b0;
        total++; if (result_valid_o !== 1'b1 || result_id_o !== 3'd1 || result_o !== {32{8'h3D}}) begin
            bad++; $display("FAIL spur_deliver got v=%b id=%0d data=%h exp=1 1 3d..3d", result_valid_o, result_id_o, result_o); end
        result_ack_i = 1'b1;
        tick();
        result_ack_i = 1'b0;
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL spur_end got=%0d exp=0", state_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_coincide();
        test_reset_wait();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
